persp_recip_div: RTL and testbench

- Iterative radix-2 restoring divider computing the per-scanline perspective step, recip = floor(2^SHIFT / denom), for the 3D checkerboard plane.
- Sits directly upstream of the pixel/plane renderer. The renderer pulses start during the previous line with denom = plane row + 1, then latches recip at hblank.
- Fixed, data-independent latency. The result holds between operations so the consumer may sample it at any later cycle.

---
 rtl/persp_recip_div.sv | 123 ++++++++++++
 tb/tb_persp_recip_div.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/persp_recip_div.sv
// Radix-2 restoring divider producing recip = floor(2^SHIFT / denom), saturated to Q_W bits.
// Fixed latency of SHIFT+2 cycles from accepted start to the done pulse; recip holds between operations.
module persp_recip_div #(
    parameter int DEN_W = 10,
    parameter int Q_W   = 11,
    parameter int SHIFT = 16
) (
    input  logic             clk48,
    input  logic             rst,
    input  logic             start,
    input  logic [DEN_W-1:0] denom,
    output logic [Q_W-1:0]   recip,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(SHIFT + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(SHIFT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DEN_W-1:0]   d_q, d_d;
    logic [DEN_W:0]     rem_q, rem_d;
    logic [SHIFT:0]     quo_q, quo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [Q_W-1:0]     recip_q, recip_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               nbit;
    logic [DEN_W:0]     rem_sh;
    logic               ge;
    logic               accept;

    // Clamp quotients that do not fit in Q_W bits to all ones.
    function automatic logic [Q_W-1:0] sat_q(input logic [SHIFT:0] q);
        if (|(q >> Q_W))
            return '1;
        return Q_W'(q);
    endfunction

    // Numerator is a single 1 at bit SHIFT, so only the first iteration shifts in a one.
    assign nbit   = (cnt_q == CNT_TOP);
    assign rem_sh = {rem_q[DEN_W-1:0], nbit};
    // rem_q[DEN_W] set means the shifted value overflowed rem_sh and is certainly >= d.
    assign ge     = rem_q[DEN_W] || (rem_sh >= {1'b0, d_q});
    assign accept = start && ((state_q == IDLE) || (state_q == FINISH));

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        recip_d = recip_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                rem_d = ge ? (rem_sh - {1'b0, d_q}) : rem_sh;
                quo_d = {quo_q[SHIFT-1:0], ge};
                if (cnt_q == '0)
                    state_d = FINISH;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            FINISH: begin
                recip_d = sat_q(quo_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start in FINISH chains straight into the next operation.
        if (accept) begin
            state_d = CALC;
            d_d     = denom;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CNT_TOP;
        end

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            recip_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            recip_q <= recip_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign recip = recip_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_persp_recip_div.sv
// Self-checking bench for persp_recip_div: scenario tasks checked against an arithmetic reference
// of floor(65536/denom) clamped to 2047.
module tb_persp_recip_div;

    logic        clk48;
    logic        rst;
    logic        start;
    logic [9:0]  denom;
    logic [10:0] recip;
    logic        busy;
    logic        done;

    int checks;
    int failures;
    logic [10:0] held;

    persp_recip_div #(.DEN_W(10), .Q_W(11), .SHIFT(16)) dut (
        .clk48 (clk48),
        .rst   (rst),
        .start (start),
        .denom (denom),
        .recip (recip),
        .busy  (busy),
        .done  (done)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    function automatic logic [10:0] ref_recip(input int d);
        int q;
        if (d == 0) return 11'd2047;
        q = 65536 / d;
        if (q > 2047) q = 2047;
        return 11'(q);
    endfunction

    // Issues one start and watches 60 cycles after the accepting edge (k = edges since acceptance).
    task automatic run_op(input logic [9:0] d, input bit hazard, input bit b2b, input logic [9:0] d2,
                          input logic [10:0] prev,
                          output int lat1, output int lat2, output int ndone, output int nbusy,
                          output logic [10:0] r1, output logic [10:0] r2, output bit hold_ok);
        lat1 = -1; lat2 = -1; ndone = 0; nbusy = 0; r1 = '0; r2 = '0; hold_ok = 1'b1;
        @(negedge clk48);
        start = 1'b1;
        denom = d;
        @(negedge clk48);
        start = 1'b0;
        denom = 10'($urandom);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk48);
            if (done === 1'b1) begin
                ndone++;
                if (lat1 < 0) begin lat1 = k; r1 = recip; end
                else if (lat2 < 0) begin lat2 = k; r2 = recip; end
            end else begin
                if (lat1 < 0 && recip !== prev) hold_ok = 1'b0;
                if (lat1 >= 0 && lat2 < 0 && recip !== r1) hold_ok = 1'b0;
            end
            if (lat1 < 0 && busy === 1'b1) nbusy++;
            start = 1'b0;
            if (hazard && (k == 2 || k == 9)) begin start = 1'b1; denom = 10'd5; end
            if (b2b && k == 17) begin start = 1'b1; denom = d2; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk48);
        rst = 1'b1; start = 1'b0; denom = '0;
        @(posedge clk48);
        @(posedge clk48);
        @(negedge clk48);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk48);
            checks++;
            if (recip !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got recip=%0d busy=%b done=%b want 0/0/0", i, recip, busy, done);
            end
        end
        held = 11'd0;
    endtask

    task automatic test_basic();
        int lat1, lat2, nd, nb;
        logic [10:0] r1, r2;
        bit hold;
        logic [9:0] tbl [5] = '{10'd64, 10'd33, 10'd1023, 10'd1, 10'd0};
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i], 1'b0, 1'b0, 10'd0, held, lat1, lat2, nd, nb, r1, r2, hold);
            checks++;
            if (r1 !== ref_recip(int'(tbl[i])) || lat1 != 18) begin
                failures++;
                $display("FAIL basic_div denom=%0d got recip=%0d lat=%0d want recip=%0d lat=18",
                         tbl[i], r1, lat1, ref_recip(int'(tbl[i])));
            end
            checks++;
            if (nb != 17 || nd != 1 || !hold) begin
                failures++;
                $display("FAIL basic_ctrl denom=%0d got busy_cycles=%0d dones=%0d hold=%0d want 17/1/1",
                         tbl[i], nb, nd, hold);
            end
            held = ref_recip(int'(tbl[i]));
        end
    endtask

    task automatic test_random();
        int lat1, lat2, nd, nb;
        logic [10:0] r1, r2;
        bit hold;
        logic [9:0] d;
        for (int i = 0; i < 12; i++) begin
            d = 10'($urandom_range(0, 1023));
            run_op(d, 1'b0, 1'b0, 10'd0, held, lat1, lat2, nd, nb, r1, r2, hold);
            checks++;
            if (r1 !== ref_recip(int'(d)) || lat1 != 18 || nd != 1 || !hold) begin
                failures++;
                $display("FAIL random_div denom=%0d got recip=%0d lat=%0d dones=%0d hold=%0d want recip=%0d lat=18",
                         d, r1, lat1, nd, hold, ref_recip(int'(d)));
            end
            held = ref_recip(int'(d));
        end
    endtask

    task automatic test_hazard();
        int lat1, lat2, nd, nb;
        logic [10:0] r1, r2;
        bit hold;
        run_op(10'd64, 1'b1, 1'b0, 10'd0, held, lat1, lat2, nd, nb, r1, r2, hold);
        checks++;
        if (r1 !== 11'd1024 || lat1 != 18 || nd != 1 || !hold) begin
            failures++;
            $display("FAIL hazard_ignore got recip=%0d lat=%0d dones=%0d hold=%0d want 1024/18/1/1", r1, lat1, nd, hold);
        end
        held = 11'd1024;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, nd, nb;
        logic [10:0] r1, r2;
        bit hold;
        run_op(10'd100, 1'b0, 1'b1, 10'd200, held, lat1, lat2, nd, nb, r1, r2, hold);
        checks++;
        if (r1 !== ref_recip(100) || lat1 != 18) begin
            failures++;
            $display("FAIL b2b_first got recip=%0d lat=%0d want %0d/18", r1, lat1, ref_recip(100));
        end
        checks++;
        if (r2 !== ref_recip(200) || lat2 != 36 || nd != 2 || !hold) begin
            failures++;
            $display("FAIL b2b_second got recip=%0d lat=%0d dones=%0d hold=%0d want %0d/36/2/1",
                     r2, lat2, nd, hold, ref_recip(200));
        end
        held = ref_recip(200);
    endtask

    task automatic test_reset_midop();
        int lat1, lat2, nd, nb, extra;
        logic [10:0] r1, r2;
        bit hold;
        run_op(10'd100, 1'b0, 1'b0, 10'd0, held, lat1, lat2, nd, nb, r1, r2, hold);
        checks++;
        if (r1 !== 11'd655) begin
            failures++;
            $display("FAIL midop_setup got recip=%0d want 655", r1);
        end
        @(negedge clk48);
        start = 1'b1; denom = 10'd64;
        @(negedge clk48);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clk48);
        rst = 1'b1;
        @(negedge clk48);
        checks++;
        if (recip !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset got recip=%0d busy=%b done=%b want 0/0/0", recip, busy, done);
        end
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk48);
            if (done !== 1'b0 || recip !== 11'd0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL midop_quiet got bad_cycles=%0d want 0", extra);
        end
        held = 11'd0;
        run_op(10'd64, 1'b0, 1'b0, 10'd0, held, lat1, lat2, nd, nb, r1, r2, hold);
        checks++;
        if (r1 !== 11'd1024 || lat1 != 18 || nd != 1 || !hold) begin
            failures++;
            $display("FAIL midop_restart got recip=%0d lat=%0d dones=%0d hold=%0d want 1024/18/1/1", r1, lat1, nd, hold);
        end
        held = 11'd1024;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        denom = '0;
        held = '0;
        test_reset();
        test_basic();
        test_hazard();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
